// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the push-button SR controller.
package sr_ctrl_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        QUAL_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        QUAL_RELEASE = 2'd3
    } dbnc_state_e;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM and qualification counter.
// press_c_o is combinational and high on the edge that accepts a press.
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_c_o
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s_btn;
    dbnc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign s_btn = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is reloaded on every state change, so it only ever counts up to CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s_btn) begin
                    state_d = QUAL_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL_PRESS: begin
                if (!s_btn) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_btn) begin
                    state_d = QUAL_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            QUAL_RELEASE: begin
                if (s_btn) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        press_c_o = 1'b0;
        if ((state_q == QUAL_PRESS) && s_btn && (cnt_q == CNT_LAST)) begin
            press_c_o = 1'b1;
        end
    end

endmodule

// File: rtl/sr_btn_ctrl.sv
// Debounced set/reset push-button front end driving a downstream SR stage.
// Simultaneous presses are reported as a conflict instead of set or reset.
module sr_btn_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set_i,
    input  logic btn_reset_i,
    output logic set_o,
    output logic reset_o,
    output logic conflict_o
);

    logic press_set_c;
    logic press_reset_c;
    logic set_d, reset_d, conflict_d;
    logic set_q, reset_q, conflict_q;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_set (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_set_i),
        .press_c_o (press_set_c)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_reset (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_reset_i),
        .press_c_o (press_reset_c)
    );

    // Arbitration: a same-edge collision suppresses both commands.
    always_comb begin
        set_d      = press_set_c & ~press_reset_c;
        reset_d    = press_reset_c & ~press_set_c;
        conflict_d = press_set_c & press_reset_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q      <= 1'b0;
            reset_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            set_q      <= set_d;
            reset_q    <= reset_d;
            conflict_q <= conflict_d;
        end
    end

    assign set_o      = set_q;
    assign reset_o    = reset_q;
    assign conflict_o = conflict_q;

endmodule

// File: tb/tb_sr_btn_ctrl.sv
// Directed bench for sr_btn_ctrl with DEBOUNCE_CYCLES=4; expected edges are hand-derived.
module tb_sr_btn_ctrl;
    import sr_ctrl_pkg::*;

    localparam int unsigned N = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic btn_set   = 1'b0;
    logic btn_reset = 1'b0;
    logic set_o, reset_o, conflict_o;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int set_count, reset_count, conflict_count, overlap_cnt;
    int last_set_edge, last_reset_edge, last_conflict_edge;
    int e0;

    sr_btn_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_set_i   (btn_set),
        .btn_reset_i (btn_reset),
        .set_o       (set_o),
        .reset_o     (reset_o),
        .conflict_o  (conflict_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Pulse monitor: records count and the posedge index that launched each pulse.
    always @(negedge clk) begin
        if (set_o) begin
            set_count++;
            last_set_edge = edge_cnt;
        end
        if (reset_o) begin
            reset_count++;
            last_reset_edge = edge_cnt;
        end
        if (conflict_o) begin
            conflict_count++;
            last_conflict_edge = edge_cnt;
        end
        if (set_o && reset_o) overlap_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        set_count          = 0;
        reset_count        = 0;
        conflict_count     = 0;
        last_set_edge      = -1;
        last_reset_edge    = -1;
        last_conflict_edge = -1;
    endtask

    initial begin
        overlap_cnt = 0;
        clear_counts();

        // Reset state, asserted from time zero
        #1;
        check("rst_set", int'(set_o), 0);
        check("rst_reset", int'(reset_o), 0);
        check("rst_conflict", int'(conflict_o), 0);
        check("rst_state_set", int'(dut.u_dbnc_set.state_q), int'(IDLE));
        check("rst_cnt_set", int'(dut.u_dbnc_set.cnt_q), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single held set press, then release
        clear_counts();
        btn_set = 1'b1;
        e0 = edge_cnt + 1;
        tick(12);
        check("held_set_count", set_count, 1);
        check("held_set_edge", last_set_edge, e0 + 5);
        check("held_reset_count", reset_count, 0);
        check("held_conflict_count", conflict_count, 0);
        check("held_state", int'(dut.u_dbnc_set.state_q), int'(PRESSED));
        btn_set = 1'b0;
        tick(12);
        check("release_no_pulse", set_count, 1);
        check("release_state", int'(dut.u_dbnc_set.state_q), int'(IDLE));

        // Short 3-cycle reset press is rejected
        clear_counts();
        btn_reset = 1'b1;
        tick(3);
        btn_reset = 1'b0;
        tick(10);
        check("short_reset_count", reset_count, 0);
        check("short_reset_state", int'(dut.u_dbnc_reset.state_q), int'(IDLE));

        // Bounce 1-0-1-0 then stable high
        clear_counts();
        btn_set = 1'b1; tick(1);
        btn_set = 1'b0; tick(1);
        btn_set = 1'b1; tick(1);
        btn_set = 1'b0; tick(1);
        btn_set = 1'b1;
        e0 = edge_cnt + 1;
        tick(20);
        check("bounce_set_count", set_count, 1);
        check("bounce_set_edge", last_set_edge, e0 + 5);
        btn_set = 1'b0;
        tick(12);

        // Simultaneous presses -> conflict only
        clear_counts();
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        e0 = edge_cnt + 1;
        tick(12);
        check("conf_count", conflict_count, 1);
        check("conf_edge", last_conflict_edge, e0 + 5);
        check("conf_set_count", set_count, 0);
        check("conf_reset_count", reset_count, 0);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        tick(12);

        // Reset mid-qualification aborts, then fresh press after reset
        clear_counts();
        btn_set = 1'b1;
        e0 = edge_cnt + 1;
        tick(3);
        check("midq_state", int'(dut.u_dbnc_set.state_q), int'(QUAL_PRESS));
        rst_n = 1'b0;
        #1;
        check("midq_abort_state", int'(dut.u_dbnc_set.state_q), int'(IDLE));
        check("midq_abort_sync", int'(dut.u_dbnc_set.sync_q), 0);
        tick(1);
        rst_n = 1'b1;
        tick(14);
        check("midq_set_count", set_count, 1);
        check("midq_set_edge", last_set_edge, e0 + 9);
        btn_set = 1'b0;
        tick(12);

        // Two separate presses give two pulses
        clear_counts();
        btn_set = 1'b1;
        tick(50);
        btn_set = 1'b0;
        tick(10);
        btn_set = 1'b1;
        e0 = edge_cnt + 1;
        tick(20);
        check("repress_count", set_count, 2);
        check("repress_edge", last_set_edge, e0 + 5);

        // Short glitch low while pressed keeps PRESSED with no new pulse
        clear_counts();
        btn_set = 1'b0; tick(2);
        btn_set = 1'b1; tick(10);
        check("glitch_count", set_count, 0);
        check("glitch_state", int'(dut.u_dbnc_set.state_q), int'(PRESSED));
        btn_set = 1'b0;
        tick(12);

        // Staggered presses: both pulse on their own edges
        clear_counts();
        btn_set = 1'b1;
        e0 = edge_cnt + 1;
        tick(2);
        btn_reset = 1'b1;
        tick(12);
        check("stag_set_edge", last_set_edge, e0 + 5);
        check("stag_reset_edge", last_reset_edge, e0 + 7);
        check("stag_set_count", set_count, 1);
        check("stag_reset_count", reset_count, 1);
        check("stag_conflict_count", conflict_count, 0);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        tick(12);

        // Asynchronous reset clears a live SET pulse immediately
        clear_counts();
        btn_set = 1'b1;
        tick(6);
        check("live_set_high", int'(set_o), 1);
        rst_n = 1'b0;
        #1;
        check("async_clear_set", int'(set_o), 0);
        tick(1);
        rst_n = 1'b1;
        btn_set = 1'b0;
        tick(12);

        check("never_set_and_reset", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sr_btn_ctrl.md
SR_BTN_CTRL -- requirements
Module: sr_btn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 CLK  input  1  sole clock; all state updates on posedge.
REQ-003 RSTN  input  1  reset, asynchronous assert, active-low.
REQ-004 BTN_SET  input  1  raw, bouncy, asynchronous set push-button, high = pressed.
REQ-005 BTN_RESET  input  1  raw, bouncy, asynchronous reset push-button, high = pressed.
REQ-006 SET  output  1  registered one-cycle set pulse to the downstream SR flip-flop stage.
REQ-007 RESET  output  1  registered one-cycle reset pulse to the downstream SR flip-flop stage.
REQ-008 CONFLICT  output  1  registered one-cycle flag: both presses qualified on the same edge.

Function
REQ-009 Each BTN_* input SHALL pass through its own 2-flop synchronizer; its output is S_x.
REQ-010 Each channel SHALL run a debounce FSM with states IDLE, QUAL_PRESS, PRESSED and QUAL_RELEASE, plus a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-011 The debounce FSM SHALL make these transitions:
- IDLE: S_x=1 -> QUAL_PRESS, cnt=1.
- QUAL_PRESS: S_x=0 -> IDLE; S_x=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED and emit press event; otherwise cnt+1.
- PRESSED: S_x=0 -> QUAL_RELEASE, cnt=1.
- QUAL_RELEASE: S_x=1 -> PRESSED; S_x=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-012 The counter SHALL never wrap; it is reloaded on every state entry.
REQ-013 With N=DEBOUNCE_CYCLES and BTN_x held high, the press event SHALL make SET/RESET high for exactly the one cycle following posedge N+1, where posedge 0 is the edge that first samples BTN_x high.
REQ-014 Release SHALL generate no output pulse.
REQ-015 A held button SHALL produce exactly one pulse per press; re-arming requires a qualified release back to IDLE.
REQ-016 Any glitch shorter than N samples SHALL produce no pulse and SHALL return the FSM to its prior stable state.
REQ-017 A set press event alone SHALL pulse SET only, and a reset press event alone SHALL pulse RESET only.
REQ-018 Set and reset press events on the same edge SHALL suppress both SET and RESET and SHALL pulse CONFLICT for one cycle.
REQ-019 SET and RESET SHALL never be high in the same cycle.
REQ-020 Press events on different edges SHALL each pulse normally, with no cross-channel lockout.

Reset
REQ-021 While RSTN=0, synchronizers SHALL be 0, both FSMs SHALL be in IDLE, counters SHALL be 0, and SET, RESET and CONFLICT SHALL be 0, immediately and independent of CLK.
REQ-022 An RSTN assertion mid-qualification or mid-press SHALL abort the operation with no pulse.
REQ-023 After RSTN deasserts with a button already held, that button SHALL qualify as a fresh press, pulsing per REQ-013 counted from the first post-reset sampling edge.

Structure
REQ-024 Package sr_ctrl_pkg SHALL hold the debounce state enum (IDLE, QUAL_PRESS, PRESSED, QUAL_RELEASE) and the default DEBOUNCE_CYCLES constant.
REQ-025 Sub-module sr_debounce SHALL contain one synchronizer, FSM and counter and emit a one-cycle press event.
REQ-026 sr_btn_ctrl SHALL instantiate sr_debounce twice and contain only the arbitration and output registers.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 BTN_SET held high from edge 0 -> SET=1 only in the cycle after edge 5; RESET=0 and CONFLICT=0 throughout.
REQ-028 BTN_RESET pulsed high for 3 cycles, then low -> no RESET pulse; FSM back in IDLE.
REQ-029 BTN_SET bouncing 1-0-1-0 then stable high for 20 cycles -> exactly one SET pulse, 6 edges after the start of the stable level.
REQ-030 BTN_SET and BTN_RESET rising on the same edge and held -> CONFLICT pulses once; SET=0 and RESET=0.
REQ-031 BTN_SET held; RSTN pulsed low at edge 3 for 1 cycle -> no pulse before reset; one SET pulse 6 edges after the first post-reset sampling edge.
REQ-032 BTN_SET held 50 cycles, released for 10 cycles, pressed again -> exactly two SET pulses.
